// File: rtl/venus_mem_pkg.sv
// Shared constants for the venus instruction/data memory: port widths and
// response-owner encodings used by ifetch, the LSU and the port arbiter.
package venus_mem_pkg;

  localparam int unsigned ADDR_W           = 16;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned MAX_LS_BURST_DEF = 4;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IF    = 2'd1;
  localparam logic [1:0] OWN_LS_RD = 2'd2;

endpackage : venus_mem_pkg

// File: rtl/imem_arb_fair_cnt.sv
// Grant decision between fetch and LSU, with a burst counter that caps how many
// consecutive LSU grants fetch can be made to wait behind.
module imem_arb_fair_cnt
  import venus_mem_pkg::*;
#(
  parameter int unsigned MAX_LS_BURST = MAX_LS_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_req,
  output logic ls_gnt,
  output logic if_gnt
);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;

  // LSU wins until it has taken MAX_LS_BURST grants in a row over a waiting fetch.
  always_comb begin
    ls_gnt        = ls_req & (~if_req | (burst_cnt < CNT_W'(MAX_LS_BURST)));
    if_gnt        = if_req & ~ls_gnt;
    burst_cnt_nxt = burst_cnt;
    if (~if_req | if_gnt) begin
      burst_cnt_nxt = '0;
    end else if (ls_gnt) begin
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else begin
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule : imem_arb_fair_cnt

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction/data memory between fetch and the LSU and
// routes the one-cycle-late read data back to whichever side issued the read.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W       = venus_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W       = venus_mem_pkg::DATA_W,
  parameter int unsigned MAX_LS_BURST = venus_mem_pkg::MAX_LS_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_stall_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_q_i
);

  import venus_mem_pkg::OWN_NONE;
  import venus_mem_pkg::OWN_IF;
  import venus_mem_pkg::OWN_LS_RD;

  logic       ls_gnt;
  logic       if_gnt;
  logic [1:0] resp_own;
  logic [1:0] resp_own_nxt;

  imem_arb_fair_cnt #(
    .MAX_LS_BURST (MAX_LS_BURST)
  ) u_fair_cnt (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req_i),
    .ls_req (ls_req_i),
    .ls_gnt (ls_gnt),
    .if_gnt (if_gnt)
  );

  // Memory port follows the granted requester; enables are held low in reset.
  always_comb begin
    mem_en_o   = rst & (ls_gnt | if_gnt);
    mem_we_o   = rst & ls_gnt & ls_we_i;
    mem_addr_o = '0;
    mem_d_o    = '0;
    if (ls_gnt) begin
      mem_addr_o = ls_addr_i;
      mem_d_o    = ls_wdata_i;
    end else if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end
    if_stall_o = if_req_i & ~if_gnt;
    ls_gnt_o   = ls_gnt;
  end

  // Remember who owns the data coming back next cycle; LSU writes return nothing.
  always_comb begin
    resp_own_nxt = OWN_NONE;
    if (if_gnt) begin
      resp_own_nxt = OWN_IF;
    end else if (ls_gnt & ~ls_we_i) begin
      resp_own_nxt = OWN_LS_RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_own <= OWN_NONE;
    end else begin
      resp_own <= resp_own_nxt;
    end
  end

  always_comb begin
    if_valid_o = (resp_own == OWN_IF);
    ls_valid_o = (resp_own == OWN_LS_RD);
    if_inst_o  = if_valid_o ? mem_q_i : '0;
    ls_rdata_o = ls_valid_o ? mem_q_i : '0;
  end

endmodule : imem_port_arbiter

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a behavioural
// synchronous single-port memory behind it.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_stall;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic [31:0] ls_rdata;
  logic        ls_valid;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  logic [31:0] mem [0:511];

  int n_checks;
  int n_fail;

  imem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_stall_o (if_stall),
    .if_inst_o  (if_inst),
    .if_valid_o (if_valid),
    .ls_req_i   (ls_req),
    .ls_we_i    (ls_we),
    .ls_addr_i  (ls_addr),
    .ls_wdata_i (ls_wdata),
    .ls_gnt_o   (ls_gnt),
    .ls_rdata_o (ls_rdata),
    .ls_valid_o (ls_valid),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_d_o    (mem_d),
    .mem_q_i    (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[8:0]] <= mem_d;
      else        mem_q <= mem[mem_addr[8:0]];
    end
  end

  // Apply one cycle of requests just after the rising edge, return at the falling edge.
  task automatic cycle(input logic ir, input logic [15:0] ia, input logic lr,
                       input logic lw, input logic [15:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0000; ls_req = 1'b1; ls_we = 1'b0;
    ls_addr = 16'h0000; ls_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_en: en=%b we=%b required 0/0", mem_en, mem_we);
    end
    n_checks++;
    if (if_valid !== 1'b0 || ls_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids: if=%b ls=%b required 0/0", if_valid, ls_valid);
    end
    n_checks++;
    if (if_inst !== 32'h0 || ls_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: if=%h ls=%h required 0/0", if_inst, ls_rdata);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ls_gnt !== 1'b1 || if_stall !== 1'b1 || mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: ls_gnt=%b if_stall=%b mem_en=%b required 1/1/1",
               ls_gnt, if_stall, mem_en);
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_fetch_only;
    for (int i = 0; i < 6; i++) begin
      cycle(i < 5, 16'(i), 1'b0, 1'b0, 16'h0, 32'h0);
      if (i < 5) begin
        n_checks++;
        if (if_stall !== 1'b0) begin
          n_fail++; $display("FAIL fetch_stall[%0d]: got %b required 0", i, if_stall);
        end
      end
      n_checks++;
      if (if_valid !== (i > 0) || ls_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_valid[%0d]: if=%b ls=%b required %b/0", i, if_valid, ls_valid, i > 0);
      end
      if (i > 0) begin
        n_checks++;
        if (if_inst !== (32'h1000_0000 | 32'(i - 1))) begin
          n_fail++;
          $display("FAIL fetch_data[%0d]: got %h required %h", i, if_inst,
                   32'h1000_0000 | 32'(i - 1));
        end
      end
    end
  endtask

  task automatic test_starvation;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 32'h0);
      n_checks++;
      if (ls_gnt !== ((i % 5) != 4) || if_stall !== ((i % 5) != 4)) begin
        n_fail++;
        $display("FAIL starve[%0d]: ls_gnt=%b if_stall=%b required %b/%b", i, ls_gnt,
                 if_stall, (i % 5) != 4, (i % 5) != 4);
      end
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_write_read;
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0100, 32'hDEAD_BEEF);
    n_checks++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0100) begin
      n_fail++;
      $display("FAIL wr_issue: gnt=%b we=%b addr=%h required 1/1/0100", ls_gnt, mem_we, mem_addr);
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 32'h0);
    n_checks++;
    if (ls_valid !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_valid: ls_valid=%b we=%b required 0/0", ls_valid, mem_we);
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    n_checks++;
    if (ls_valid !== 1'b1 || ls_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd_back: valid=%b data=%h required 1/deadbeef", ls_valid, ls_rdata);
    end
    n_checks++;
    if (if_valid !== 1'b0 || if_inst !== 32'h0) begin
      n_fail++; $display("FAIL rd_if_quiet: valid=%b data=%h required 0/0", if_valid, if_inst);
    end
  endtask

  task automatic test_interleave;
    for (int i = 0; i < 7; i++) begin
      cycle((i < 6) && (i % 2 == 0), 16'h0010, (i < 6) && (i % 2 == 1), 1'b0, 16'h0020, 32'h0);
      if (i > 0) begin
        n_checks++;
        if ((i - 1) % 2 == 0) begin
          if (if_valid !== 1'b1 || if_inst !== 32'h1000_0010 ||
              ls_valid !== 1'b0 || ls_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ilv_if[%0d]: if=%b/%h ls=%b/%h required 1/10000010 0/0", i,
                     if_valid, if_inst, ls_valid, ls_rdata);
          end
        end else begin
          if (ls_valid !== 1'b1 || ls_rdata !== 32'h1000_0020 ||
              if_valid !== 1'b0 || if_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL ilv_ls[%0d]: ls=%b/%h if=%b/%h required 1/10000020 0/0", i,
                     ls_valid, ls_rdata, if_valid, if_inst);
          end
        end
      end
    end
  endtask

  task automatic test_midop_reset;
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 32'h0);
    n_checks++;
    if (ls_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_grant: ls_gnt=%b required 1", ls_gnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; ls_req = 1'b0; if_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (ls_valid !== 1'b0 || ls_rdata !== 32'h0 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_in_reset[%0d]: ls_valid=%b data=%h en=%b required 0/0/0", i,
                 ls_valid, ls_rdata, mem_en);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1; if_req = 1'b1; if_addr = 16'h0004;
    @(negedge clk);
    n_checks++;
    if (if_stall !== 1'b0 || ls_valid !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release: stall=%b ls_valid=%b if_valid=%b required 0/0/0",
               if_stall, ls_valid, if_valid);
    end
    cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 32'h0);
    n_checks++;
    if (if_valid !== 1'b1 || if_inst !== 32'h1000_0004 || ls_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fetch_data: if=%b/%h ls_valid=%b required 1/10000004 0",
               if_valid, if_inst, ls_valid);
    end
    n_checks++;
    if (ls_gnt !== 1'b1 || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_cnt_cleared: ls_gnt=%b stall=%b required 1/1", ls_gnt, if_stall);
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mem_q    = 32'h0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 | 32'(i);
    test_reset();
    test_fetch_only();
    test_starvation();
    test_write_read();
    test_interleave();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_port_arbiter
